// File: rtl/mprj_io_cfg_pkg.sv
// Shared definitions for the user-project IO configuration block:
// register map helpers, XFER control bit and shift-engine state encoding.
package mprj_io_cfg_pkg;

    localparam int XFER_START_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } shift_state_e;

    function automatic int unsigned pwr_word(input int unsigned pads);
        return pads;
    endfunction

    function automatic int unsigned xfer_word(input int unsigned pads);
        return pads + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] wr_merge(
        input logic [31:0] old,
        input logic [31:0] dat,
        input logic [31:0] mask
    );
        return (old & ~mask) | (dat & mask);
    endfunction

endpackage

// File: rtl/mprj_io_cfg_shifter.sv
// Serialises every pad config word, highest pad first and MSB first,
// then pulses serial_load once the whole chain has been clocked.
module mprj_io_cfg_shifter
    import mprj_io_cfg_pkg::*;
#(
    parameter int IO_PADS     = 38,
    parameter int IO_CFG_BITS = 13,
    parameter int PW          = cnt_w(IO_PADS),
    parameter int BW          = cnt_w(IO_CFG_BITS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    output logic [PW-1:0]          pad_idx_o,
    input  logic [IO_CFG_BITS-1:0] pad_cfg_i,
    output logic                   serial_clock,
    output logic                   serial_data_out,
    output logic                   serial_load,
    output logic                   serial_busy
);

    localparam logic [PW-1:0] LAST_PAD = PW'(IO_PADS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(IO_CFG_BITS - 1);

    shift_state_e  state_q, state_d;
    logic [PW-1:0] pad_q, pad_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          phase_q, phase_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pad_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pad_q   <= pad_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pad_d   = pad_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SHIFT;
                    pad_d   = LAST_PAD;
                    bit_d   = LAST_BIT;
                    phase_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (bit_q == '0) begin
                        if (pad_q == '0) begin
                            state_d = ST_LOAD;
                        end else begin
                            pad_d = pad_q - 1'b1;
                            bit_d = LAST_BIT;
                        end
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
                pad_d   = '0;
                bit_d   = '0;
                phase_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pad_idx_o       = pad_q;
    assign serial_data_out = (state_q == ST_SHIFT) & pad_cfg_i[bit_q];
    assign serial_clock    = (state_q == ST_SHIFT) & phase_q;
    assign serial_load     = (state_q == ST_LOAD);
    assign serial_busy     = (state_q != ST_IDLE);

endmodule

// File: rtl/mprj_io_cfg_wb.sv
// Wishbone register block holding per-pad IO config words and power bits,
// with an XFER register that launches the serial config shift chain.
module mprj_io_cfg_wb
    import mprj_io_cfg_pkg::*;
#(
    parameter logic [31:0]            BASE_ADR    = 32'h2300_0000,
    parameter int                     IO_PADS     = 38,
    parameter int                     IO_CFG_BITS = 13,
    parameter logic [IO_CFG_BITS-1:0] IO_CFG_INIT = 13'h0403,
    parameter int                     PWR_CTRL    = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rstn_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    output logic                wb_ack_o,
    output logic [31:0]         wb_dat_o,
    output logic [PWR_CTRL-1:0] pwr_ctrl_out,
    output logic                serial_clock,
    output logic                serial_data_out,
    output logic                serial_load,
    output logic                serial_busy
);

    localparam int PW = cnt_w(IO_PADS);
    localparam logic [31:0] PWR_W  = 32'(pwr_word(IO_PADS));
    localparam logic [31:0] XFER_W = 32'(xfer_word(IO_PADS));

    logic [IO_CFG_BITS-1:0] pad_q [IO_PADS];
    logic [IO_CFG_BITS-1:0] pad_d [IO_PADS];
    logic [PWR_CTRL-1:0]    pwr_q, pwr_d;
    logic [31:0]            dat_q, dat_d;
    logic                   ack_q, ack_d;
    logic                   hold_q, hold_d;
    logic                   start_q, start_d;

    logic [31:0] off, word, mask, merged;
    logic        in_map, valid, wr, busy;
    logic [PW-1:0]          pad_idx;
    logic [IO_CFG_BITS-1:0] pad_cfg;

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            for (int i = 0; i < IO_PADS; i++) pad_q[i] <= IO_CFG_INIT;
            pwr_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            hold_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            for (int i = 0; i < IO_PADS; i++) pad_q[i] <= pad_d[i];
            pwr_q   <= pwr_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            hold_q  <= hold_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        off    = wb_adr_i - BASE_ADR;
        word   = {2'b00, off[31:2]};
        in_map = word < (32'(IO_PADS) + 32'd2);
        // One ack per bus request: hold blocks re-ack until the master lets go.
        valid  = wb_stb_i & wb_cyc_i & in_map & ~hold_q & ~ack_q;
        wr     = valid & wb_we_i;
        mask   = lane_mask(wb_sel_i);
        busy   = serial_busy | start_q;
        merged = '0;

        for (int i = 0; i < IO_PADS; i++) pad_d[i] = pad_q[i];
        pwr_d   = pwr_q;
        dat_d   = '0;
        ack_d   = valid;
        start_d = 1'b0;
        hold_d  = hold_q;

        if (!(wb_stb_i | wb_cyc_i)) hold_d = 1'b0;
        else if (valid)             hold_d = 1'b1;

        for (int i = 0; i < IO_PADS; i++) begin
            if (word == 32'(i)) begin
                if (wr && !busy) begin
                    merged   = wr_merge(32'(pad_q[i]), wb_dat_i, mask);
                    pad_d[i] = merged[IO_CFG_BITS-1:0];
                end
                if (valid && !wb_we_i) dat_d = 32'(pad_q[i]);
            end
        end

        if (word == PWR_W) begin
            if (wr) begin
                merged = wr_merge(32'(pwr_q), wb_dat_i, mask);
                pwr_d  = merged[PWR_CTRL-1:0];
            end
            if (valid && !wb_we_i) dat_d = 32'(pwr_q);
        end

        if (word == XFER_W) begin
            if (wr && wb_sel_i[0] && wb_dat_i[XFER_START_BIT] && !busy)
                start_d = 1'b1;
            if (valid && !wb_we_i) dat_d = {31'b0, busy};
        end
    end

    assign pad_cfg      = pad_q[pad_idx];
    assign wb_ack_o     = ack_q;
    assign wb_dat_o     = dat_q;
    assign pwr_ctrl_out = pwr_q;

    mprj_io_cfg_shifter #(
        .IO_PADS     (IO_PADS),
        .IO_CFG_BITS (IO_CFG_BITS)
    ) u_shifter (
        .clk             (wb_clk_i),
        .rst_n           (wb_rstn_i),
        .start_i         (start_q),
        .pad_idx_o       (pad_idx),
        .pad_cfg_i       (pad_cfg),
        .serial_clock    (serial_clock),
        .serial_data_out (serial_data_out),
        .serial_load     (serial_load),
        .serial_busy     (serial_busy)
    );

endmodule

// File: tb/tb_mprj_io_cfg_wb.sv
// Directed bench for mprj_io_cfg_wb with a 4-pad, 4-bit configuration:
// register access, byte lanes, shift stream, busy handling and reset abort.
module tb_mprj_io_cfg_wb;

    localparam logic [31:0] BASE = 32'h2300_0000;
    localparam logic [31:0] PWR  = BASE + 32'h10;
    localparam logic [31:0] XFER = BASE + 32'h14;
    localparam logic [31:0] BAD  = BASE + 32'h18;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic [3:0]  pwr;
    logic        sclk, sdat, sload, sbusy;

    int tests = 0;
    int failed = 0;
    int sclk_cnt = 0;
    int load_cnt = 0;
    int busy_cnt = 0;
    logic [15:0] sbits = '0;

    mprj_io_cfg_wb #(
        .BASE_ADR    (BASE),
        .IO_PADS     (4),
        .IO_CFG_BITS (4),
        .IO_CFG_INIT (4'h3),
        .PWR_CTRL    (4)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rstn_i       (rstn),
        .wb_stb_i        (stb),
        .wb_cyc_i        (cyc),
        .wb_we_i         (we),
        .wb_sel_i        (sel),
        .wb_adr_i        (adr),
        .wb_dat_i        (wdat),
        .wb_ack_o        (ack),
        .wb_dat_o        (rdat),
        .pwr_ctrl_out    (pwr),
        .serial_clock    (sclk),
        .serial_data_out (sdat),
        .serial_load     (sload),
        .serial_busy     (sbusy)
    );

    always #5 clk = ~clk;

    always @(posedge sclk) begin
        sbits    = {sbits[14:0], sdat};
        sclk_cnt = sclk_cnt + 1;
    end

    always @(negedge clk) begin
        if (sbusy) busy_cnt = busy_cnt + 1;
        if (sload) load_cnt = load_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic acked, output logic ack2,
                        output logic [31:0] rd);
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0; ack2 = 1'b0; rd = '0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rd = rdat;
                break;
            end
        end
        if (acked) begin
            @(posedge clk); #1;
            ack2 = ack;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        logic k, k2;
        logic [31:0] r;
        xact(1'b1, a, d, s, k, k2, r);
        chk({tag, "_ack"}, {31'b0, k}, 32'd1);
        chk({tag, "_ack1cyc"}, {31'b0, k2}, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic k, k2;
        logic [31:0] r;
        xact(1'b0, a, '0, 4'hF, k, k2, r);
        chk({tag, "_ack"}, {31'b0, k}, 32'd1);
        chk({tag, "_ack1cyc"}, {31'b0, k2}, 32'd0);
        chk({tag, "_data"}, r, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (sbusy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done"}, {31'b0, sbusy}, 32'd0);
    endtask

    initial begin
        logic [31:0] v [4];
        logic k, k2;
        logic [31:0] r;
        int n;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {26'b0, ack, pwr, sclk, sdat, sload, sbusy}, 32'd0);
        chk("reset_dat", rdat, 32'd0);
        rstn = 1'b1;

        rd("init_pad0", BASE, 32'h3);
        rd("init_pad3", BASE + 32'hC, 32'h3);
        rd("init_xfer", XFER, 32'h0);

        for (int i = 0; i < 4; i++) v[i] = $urandom;
        for (int i = 0; i < 4; i++)
            wr($sformatf("pad%0d_wr", i), BASE + 32'(4 * i), v[i], 4'hF);
        for (int i = 0; i < 4; i++)
            rd($sformatf("pad%0d_rd", i), BASE + 32'(4 * i), {28'b0, v[i][3:0]});

        wr("pad1_lane_off", BASE + 32'h4, ~v[1], 4'b1110);
        rd("pad1_lane_off", BASE + 32'h4, {28'b0, v[1][3:0]});

        wr("pwr_wr", PWR, 32'hFFFF_FFFF, 4'b0001);
        rd("pwr_rd", PWR, 32'h0000_000F);
        chk("pwr_out", {28'b0, pwr}, 32'hF);

        wr("pad3", BASE + 32'hC, 32'hA, 4'hF);
        wr("pad2", BASE + 32'h8, 32'h5, 4'hF);
        wr("pad1", BASE + 32'h4, 32'hC, 4'hF);
        wr("pad0", BASE + 32'h0, 32'h3, 4'hF);
        sclk_cnt = 0; load_cnt = 0; busy_cnt = 0; sbits = '0;
        wr("xfer1", XFER, 32'h1, 4'hF);
        wait_idle("xfer1");
        repeat (2) @(posedge clk);
        chk("xfer1_bits", {16'b0, sbits}, 32'h0000_A5C3);
        chk("xfer1_clks", 32'(sclk_cnt), 32'd16);
        chk("xfer1_loads", 32'(load_cnt), 32'd1);
        chk("xfer1_busy", 32'(busy_cnt), 32'd33);

        sclk_cnt = 0; load_cnt = 0; busy_cnt = 0; sbits = '0;
        wr("xfer2", XFER, 32'h1, 4'hF);
        wr("busy_pad0", BASE, 32'hF, 4'hF);
        wr("busy_xfer", XFER, 32'h1, 4'hF);
        rd("busy_pad0", BASE, 32'h3);
        rd("busy_stat", XFER, 32'h1);
        wait_idle("xfer2");
        repeat (4) @(posedge clk);
        chk("xfer2_bits", {16'b0, sbits}, 32'h0000_A5C3);
        chk("xfer2_clks", 32'(sclk_cnt), 32'd16);
        chk("xfer2_loads", 32'(load_cnt), 32'd1);
        chk("xfer2_busy", 32'(busy_cnt), 32'd33);

        xact(1'b1, BAD, 32'hFFFF_FFFF, 4'hF, k, k2, r);
        chk("bad_wr_noack", {31'b0, k}, 32'd0);
        xact(1'b0, BAD, '0, 4'hF, k, k2, r);
        chk("bad_rd_noack", {31'b0, k}, 32'd0);
        rd("bad_pad0", BASE, 32'h3);
        rd("bad_pwr", PWR, 32'hF);
        chk("bad_serial", {28'b0, sclk, sdat, sload, sbusy}, 32'd0);

        sclk_cnt = 0; load_cnt = 0; busy_cnt = 0;
        wr("xfer3", XFER, 32'h1, 4'hF);
        n = 0;
        while (sclk_cnt < 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit7", 32'(sclk_cnt), 32'd7);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_outs", {26'b0, ack, pwr, sclk, sdat, sload, sbusy}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        busy_cnt = 0;
        repeat (40) @(posedge clk);
        chk("rst_no_load", 32'(load_cnt), 32'd0);
        chk("rst_no_restart", 32'(busy_cnt), 32'd0);
        for (int i = 0; i < 4; i++)
            rd($sformatf("rst_pad%0d", i), BASE + 32'(4 * i), 32'h3);
        rd("rst_pwr", PWR, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
